// File: rtl/regs_pkg.sv
// Shared types and constants for the register-file writeback path.
package regs_pkg;

  localparam int DW = 32;  // register data width
  localparam int AW = 5;   // register address width (32 registers)

  // r0 is hard-wired to zero; writes to it are discarded.
  localparam logic [AW-1:0] REG_ZERO = '0;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer: DEPTH entries of wb_entry_t, first-in first-out.
// Push into a full FIFO or pop from an empty one is ignored.
module wb_fifo
  import regs_pkg::*;
#(
  parameter int DEPTH = 4  // power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_entry_t              i_din,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CAP = (PW + 1)'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  wb_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CAP);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Entry storage; written on push only.
  // NOTE: the array has no reset; an entry is meaningful only while counted,
  // so clearing it would cost a reset tree for nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap modulo DEPTH by natural overflow; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// Writeback controller for the 2R/1W register file (r0 reads as zero).
// Arbitrates ALU results (always accepted, highest priority) and buffered
// load returns onto the single registered write port, and keeps a
// pending-write scoreboard that decode queries for RAW hazards.
module regs_wb_ctrl
  import regs_pkg::*;
#(
  parameter int DEPTH = 4  // load-return FIFO entries, power of 2, >= 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs_A,
  input  logic [AW-1:0] rs_B,
  output logic          busy_A,
  output logic          busy_B,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          L_S,
  output logic [AW-1:0] Wt_addr,
  output logic [DW-1:0] Wt_data
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_CAP = CW'(DEPTH);

  // Registered write port and scoreboard.
  logic            r_ls;
  logic [AW-1:0]   r_wt_addr;
  logic [DW-1:0]   r_wt_data;
  logic [NREG-1:0] r_sb;

  // FIFO interface.
  logic            w_fifo_push;
  logic            w_fifo_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  wb_entry_t       w_fifo_din;
  wb_entry_t       w_fifo_head;
  logic [NREG-1:0] w_sb_next;

  // A load to r0 is handshaken but never stored. ld_ready comes from the
  // registered occupancy only, so a same-cycle pop does not free a slot.
  assign ld_ready    = !w_fifo_full;
  assign w_fifo_push = ld_valid && ld_ready && (ld_rd != REG_ZERO);
  assign w_fifo_din  = '{rd: ld_rd, data: ld_data};
  // ALU owns the port whenever it is valid, even if its result is dropped.
  assign w_fifo_pop  = !alu_valid && !w_fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Select this cycle's writer and present it on the port next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ls      <= 1'b0;
      r_wt_addr <= '0;
      r_wt_data <= '0;
    end else if (alu_valid) begin
      r_ls      <= (alu_rd != REG_ZERO);
      r_wt_addr <= alu_rd;
      r_wt_data <= alu_data;
    end else if (!w_fifo_empty) begin
      r_ls      <= 1'b1;
      r_wt_addr <= w_fifo_head.rd;
      r_wt_data <= w_fifo_head.data;
    end else begin
      r_ls      <= 1'b0;
    end
  end

  assign L_S     = r_ls;
  assign Wt_addr = r_wt_addr;
  assign Wt_data = r_wt_data;

  // Scoreboard update: retire the register being written, then mark the
  // newly issued destination, so a same-edge issue keeps the bit set.
  always_comb begin
    // NOTE: default first so every path assigns w_sb_next; no latch inferred.
    w_sb_next = r_sb;
    if (r_ls)      w_sb_next[r_wt_addr] = 1'b0;
    if (iss_valid) w_sb_next[iss_rd]    = 1'b1;
    w_sb_next[REG_ZERO] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_next;
  end

  assign busy_A = r_sb[rs_A];
  assign busy_B = r_sb[rs_B];

  // Occupancy can never exceed capacity; guards the full/ready derivation.
  always_ff @(posedge clk) begin
    if (!rst) assert (w_fifo_count <= FIFO_CAP);
  end

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// Self-checking bench for regs_wb_ctrl: directed scenarios plus a random
// phase compared against a queue-based reference model.
module tb_regs_wb_ctrl;
  import regs_pkg::*;

  localparam int DEPTH = 4;
  localparam int NREG  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic [AW-1:0] rs_A = '0;
  logic [AW-1:0] rs_B = '0;
  logic          busy_A, busy_B;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_rd = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          L_S;
  logic [AW-1:0] Wt_addr;
  logic [DW-1:0] Wt_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending load returns, pending-write bits, port contents.
  wb_entry_t       m_q[$];
  logic [NREG-1:0] m_sb;
  logic            m_ls;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  always #5 clk = ~clk;

  regs_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs_A(rs_A), .rs_B(rs_B), .busy_A(busy_A), .busy_B(busy_B),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data)
  );

  function automatic void model_reset();
    m_q.delete();
    m_sb   = '0;
    m_ls   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  // One clock edge of the architectural behaviour.
  function automatic void model_edge();
    bit            accept;
    bit            old_ls;
    logic [AW-1:0] old_addr;
    wb_entry_t     e;
    accept   = ld_valid && (m_q.size() < DEPTH);
    old_ls   = m_ls;
    old_addr = m_addr;
    if (alu_valid) begin
      m_ls = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_ls = 1'b1; m_addr = e.rd; m_data = e.data;
    end else begin
      m_ls = 1'b0;
    end
    if (accept && ld_rd != 0) m_q.push_back('{rd: ld_rd, data: ld_data});
    if (old_ls)    m_sb[old_addr] = 1'b0;
    if (iss_valid) m_sb[iss_rd]   = 1'b1;
    m_sb[0] = 1'b0;
  endfunction

  task automatic drive(input logic iv, input logic [AW-1:0] ird,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] lda);
    iss_valid = iv; iss_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = lda;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    // Power-on reset state.
    n_checks++;
    if (L_S !== 1'b0 || Wt_addr !== '0 || Wt_data !== '0) begin
      n_fail++; $display("FAIL reset_port: L_S=%b addr=%0d data=%h, want 0/0/0", L_S, Wt_addr, Wt_data);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    @(posedge clk); #1;
    // Build traffic: ALU busy, three loads queued, r4 and r6 pending.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, AW'(4 + 2 * (k % 2)), 1'b1, AW'(1), DW'(k), 1'b1, AW'(11 + k), DW'(32'hB0 + k));
      tick();
    end
    idle();
    rs_A = AW'(4); rs_B = AW'(6); #1;
    n_checks++;
    if (busy_A !== 1'b1 || busy_B !== 1'b1 || m_q.size() != 3) begin
      n_fail++; $display("FAIL reset_pre: busy_A=%b busy_B=%b want 1/1 (model depth %0d)", busy_A, busy_B, m_q.size());
    end
    // Asynchronous reset mid-cycle.
    rst = 1'b1; model_reset(); #1;
    n_checks++;
    if (L_S !== 1'b0 || ld_ready !== 1'b1 || busy_A !== 1'b0 || busy_B !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: L_S=%b ld_ready=%b busy=%b%b, want 0 1 00", L_S, ld_ready, busy_A, busy_B);
    end
    n_checks++;
    if (Wt_addr !== '0 || Wt_data !== '0) begin
      n_fail++; $display("FAIL reset_async_port: addr=%0d data=%h, want 0/0", Wt_addr, Wt_data);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    // Queued entries must have been discarded: nothing gets written.
    n_checks++;
    if (L_S !== 1'b0) begin
      n_fail++; $display("FAIL reset_flush: L_S=%b, want 0", L_S);
    end
  endtask

  task automatic test_alu_path();
    drive(1'b1, AW'(5), 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    rs_A = AW'(5);
    drive(1'b0, '0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, '0);
    n_checks++;
    if (busy_A !== 1'b1) begin
      n_fail++; $display("FAIL alu_busy_pre: busy=%b, want 1", busy_A);
    end
    tick();
    n_checks++;
    if (L_S !== 1'b1 || Wt_addr !== AW'(5) || Wt_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_write: L_S=%b addr=%0d data=%h, want 1/5/deadbeef", L_S, Wt_addr, Wt_data);
    end
    n_checks++;
    if (busy_A !== 1'b1) begin
      n_fail++; $display("FAIL alu_busy_during: busy=%b, want 1", busy_A);
    end
    idle();
    tick();
    n_checks++;
    if (busy_A !== 1'b0 || L_S !== 1'b0) begin
      n_fail++; $display("FAIL alu_busy_after: busy=%b L_S=%b, want 0/0", busy_A, L_S);
    end
  endtask

  task automatic test_collision();
    drive(1'b0, '0, 1'b1, AW'(3), 32'h3333_0003, 1'b1, AW'(7), 32'h7777_0007);
    tick();
    n_checks++;
    if (L_S !== 1'b1 || Wt_addr !== AW'(3) || Wt_data !== 32'h3333_0003) begin
      n_fail++; $display("FAIL coll_alu: L_S=%b addr=%0d data=%h, want 1/3/33330003", L_S, Wt_addr, Wt_data);
    end
    idle();
    tick();
    n_checks++;
    if (L_S !== 1'b1 || Wt_addr !== AW'(7) || Wt_data !== 32'h7777_0007) begin
      n_fail++; $display("FAIL coll_ld: L_S=%b addr=%0d data=%h, want 1/7/77770007", L_S, Wt_addr, Wt_data);
    end
    tick();
    n_checks++;
    if (L_S !== 1'b0) begin
      n_fail++; $display("FAIL coll_idle: L_S=%b, want 0", L_S);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, '0, 1'b1, AW'(2), DW'(k), 1'b1, AW'(11 + k), DW'(32'hA0 + k));
      n_checks++;
      if (ld_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_ready_%0d: ld_ready=%b, want 1", k, ld_ready);
      end
      tick();
    end
    // Fifth return offered while full must be refused.
    drive(1'b0, '0, 1'b1, AW'(2), DW'(9), 1'b1, AW'(20), 32'hEEEE);
    n_checks++;
    if (ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_not_ready: ld_ready=%b, want 0", ld_ready);
    end
    tick();
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      n_checks++;
      if (L_S !== 1'b1 || Wt_addr !== AW'(11 + k) || Wt_data !== DW'(32'hA0 + k)) begin
        n_fail++; $display("FAIL full_drain_%0d: L_S=%b addr=%0d data=%h, want 1/%0d/%h",
                           k, L_S, Wt_addr, Wt_data, 11 + k, 32'hA0 + k);
      end
    end
    tick();
    n_checks++;
    if (L_S !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_refused: L_S=%b ld_ready=%b, want 0/1", L_S, ld_ready);
    end
  endtask

  task automatic test_r0();
    rs_A = '0;
    drive(1'b1, '0, 1'b1, '0, 32'h1234, 1'b1, '0, 32'h5678);
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL r0_ready: ld_ready=%b, want 1", ld_ready);
    end
    tick();
    idle();
    n_checks++;
    if (L_S !== 1'b0 || busy_A !== 1'b0) begin
      n_fail++; $display("FAIL r0_alu: L_S=%b busy0=%b, want 0/0", L_S, busy_A);
    end
    tick();
    n_checks++;
    if (L_S !== 1'b0) begin
      n_fail++; $display("FAIL r0_ld: L_S=%b, want 0", L_S);
    end
  endtask

  task automatic test_set_clear_race();
    rs_A = AW'(9);
    drive(1'b1, AW'(9), 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, 1'b1, AW'(9), 32'h9999, 1'b0, '0, '0);
    tick();
    drive(1'b1, AW'(9), 1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++;
    if (L_S !== 1'b1 || Wt_addr !== AW'(9) || busy_A !== 1'b1) begin
      n_fail++; $display("FAIL race_write: L_S=%b addr=%0d busy=%b, want 1/9/1", L_S, Wt_addr, busy_A);
    end
    tick();
    idle();
    n_checks++;
    if (busy_A !== 1'b1) begin
      n_fail++; $display("FAIL race_set_wins: busy=%b, want 1", busy_A);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rs_A = AW'($urandom_range(0, 15));
      rs_B = AW'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 9) < 4), AW'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),     AW'($urandom_range(0, 15)), DW'($urandom),
            1'($urandom_range(0, 1)),     AW'($urandom_range(0, 15)), DW'($urandom));
      n_checks++;
      if (busy_A !== m_sb[rs_A] || busy_B !== m_sb[rs_B] || ld_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_comb_%0d: busy=%b%b ready=%b, want %b%b %b",
                           n, busy_A, busy_B, ld_ready, m_sb[rs_A], m_sb[rs_B], m_q.size() < DEPTH);
      end
      tick();
      n_checks++;
      if (L_S !== m_ls || (m_ls && (Wt_addr !== m_addr || Wt_data !== m_data))) begin
        n_fail++; $display("FAIL rand_port_%0d: L_S=%b addr=%0d data=%h, want %b/%0d/%h",
                           n, L_S, Wt_addr, Wt_data, m_ls, m_addr, m_data);
      end
    end
    idle();
    for (int n = 0; n < DEPTH + 2; n++) begin
      tick();
      n_checks++;
      if (L_S !== m_ls || (m_ls && (Wt_addr !== m_addr || Wt_data !== m_data))) begin
        n_fail++; $display("FAIL rand_drain_%0d: L_S=%b addr=%0d data=%h, want %b/%0d/%h",
                           n, L_S, Wt_addr, Wt_data, m_ls, m_addr, m_data);
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_alu_path();
    test_collision();
    test_full();
    test_r0();
    test_set_clear_race();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
